// File: rtl/mem_bus_dma_pkg.sv
// Shared constants and types for the memory-bus block copier.
package mem_bus_dma_pkg;

  localparam int BUS_XLEN   = 32;
  localparam int WORD_BYTES = BUS_XLEN / 8;

  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam logic [3:0] WEN_WORD = 4'b1111;

  // Copy engine states; each bus transaction is followed by one idle gap cycle.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_FIN    = 3'd5
  } dma_state_e;

  // Word addresses have both low byte-address bits clear.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module mem_bus_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority; decrementing saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/mem_bus_dma.sv
// Bus initiator that copies len_words 32-bit words from src_addr to dst_addr,
// one read and one write per word, with an idle cycle after every handshake.
module mem_bus_dma
  import mem_bus_dma_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  src_addr,
  input  logic [XLEN-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [3:0]       mem_wen
);

  // The counter is loaded with TIMEOUT-1 on entry so that mem_valid is high
  // for exactly TIMEOUT cycles before an unanswered request is abandoned.
  localparam int              TO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LOAD   = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam bit              TO_ON     = (TIMEOUT > 0);
  localparam logic [XLEN-1:0] ADDR_STEP = XLEN'(WORD_BYTES);

  dma_state_e       state_q, state_d;
  logic [XLEN-1:0]  src_q, src_d;
  logic [XLEN-1:0]  dst_q, dst_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [3:0]       wen_q, wen_d;

  logic to_load;
  logic to_en;
  logic to_expired;
  logic timed_out;

  mem_bus_timeout #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .en       (to_en),
    .load_val (TO_LOAD),
    .expired  (to_expired)
  );

  assign timed_out = TO_ON && to_expired;

  // Next-state and datapath; bus outputs are computed one cycle ahead so
  // they come straight from flops and stay put while mem_valid is high.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    len_d   = len_q;
    words_d = words_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    to_load = 1'b0;
    to_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!is_word_aligned(src_addr[1:0]) || !is_word_aligned(dst_addr[1:0])) begin
            err_d = 1'b1;
          end else if (len_words == '0) begin
            done_d = 1'b1;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len_words;
            words_d = '0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            addr_d  = src_addr;
            wen_d   = WEN_READ;
            to_load = 1'b1;
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          src_d   = src_q + ADDR_STEP;
          valid_d = 1'b0;
          state_d = ST_RD_GAP;
        end else if (timed_out) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end

      ST_RD_GAP: begin
        valid_d = 1'b1;
        addr_d  = dst_q;
        wdata_d = data_q;
        wen_d   = WEN_WORD;
        to_load = 1'b1;
        state_d = ST_WR;
      end

      ST_WR: begin
        if (mem_ready) begin
          dst_d   = dst_q + ADDR_STEP;
          words_d = words_q + LEN_W'(1);
          valid_d = 1'b0;
          state_d = ST_WR_GAP;
        end else if (timed_out) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end

      ST_WR_GAP: begin
        if (words_q != len_q) begin
          valid_d = 1'b1;
          addr_d  = src_q;
          wen_d   = WEN_READ;
          to_load = 1'b1;
          state_d = ST_RD;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= WEN_READ;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign mem_valid  = valid_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wen    = wen_q;

endmodule
